// File: rtl/apb_rw_scheduler_if.sv
// Request/response handshakes plus APB bus seen by apb_rw_scheduler.
// slave = scheduler side, master = requesters and APB completer side.
interface apb_rw_scheduler_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              wr_req_valid, wr_req_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_rsp_valid, wr_rsp_ready, wr_rsp_err;

  logic              rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rsp_valid, rd_rsp_ready, rd_rsp_err;
  logic [DATA_W-1:0] rd_rsp_data;

  logic              PSEL, PENABLE, PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [STRB_W-1:0] PSTRB;
  logic              PREADY, PSLVERR;
  logic [DATA_W-1:0] PRDATA;

  modport slave (
    input  wr_req_valid, wr_addr, wr_data, wr_strb, wr_rsp_ready,
    output wr_req_ready, wr_rsp_valid, wr_rsp_err,
    input  rd_req_valid, rd_addr, rd_rsp_ready,
    output rd_req_ready, rd_rsp_valid, rd_rsp_err, rd_rsp_data,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PSLVERR, PRDATA
  );

  modport master (
    output wr_req_valid, wr_addr, wr_data, wr_strb, wr_rsp_ready,
    input  wr_req_ready, wr_rsp_valid, wr_rsp_err,
    output rd_req_valid, rd_addr, rd_rsp_ready,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_err, rd_rsp_data,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/apb_rw_scheduler.sv
// Round-robin read/write arbiter driving a single outstanding APB transfer.
// Optional ACCESS watchdog enabled by defining APB_TIMEOUT_EN.
module apb_rw_scheduler #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  apb_rw_scheduler_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WRSP, RRSP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              wr;
  } req_t;

  state_t            state, state_nxt;
  req_t              req_q;
  logic              last_wr;
  logic              grant_wr, grant_rd;
  logic              acc_end, tmo_hit;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_data;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // counts stalled ACCESS cycles; cleared while in SETUP so it starts at 0 on entry
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)                              tmo_cnt <= '0;
    else if (state == SETUP)                   tmo_cnt <= '0;
    else if (state == ACCESS && !bus.PREADY)   tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  assign tmo_hit = (state == ACCESS) && !bus.PREADY &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    acc_end   = 1'b0;
    // tie goes to whichever type was not granted last
    grant_wr  = bus.wr_req_valid && (!bus.rd_req_valid || !last_wr);
    grant_rd  = bus.rd_req_valid && !grant_wr;
    case (state)
      IDLE:   if (grant_wr || grant_rd) state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: if (bus.PREADY || tmo_hit) begin
                acc_end   = 1'b1;
                state_nxt = req_q.wr ? WRSP : RRSP;
              end
      WRSP:   if (bus.wr_rsp_ready) state_nxt = IDLE;
      RRSP:   if (bus.rd_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= IDLE;
      req_q    <= '0;
      last_wr  <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (grant_wr || grant_rd)) begin
        last_wr    <= grant_wr;
        req_q.wr   <= grant_wr;
        req_q.addr <= grant_wr ? bus.wr_addr : bus.rd_addr;
        // reads keep write data and strobes at zero for their whole life
        req_q.data <= grant_wr ? bus.wr_data : '0;
        req_q.strb <= grant_wr ? bus.wr_strb : '0;
      end
      if (acc_end) begin
        rsp_err <= tmo_hit || bus.PSLVERR;
        if (!req_q.wr) rsp_data <= tmo_hit ? '0 : bus.PRDATA;
      end
    end
  end

  // ready is forced low while reset is asserted even though state is IDLE
  assign bus.wr_req_ready = ARESETn && (state == IDLE) && grant_wr;
  assign bus.rd_req_ready = ARESETn && (state == IDLE) && grant_rd;

  assign bus.PSEL    = (state == SETUP) || (state == ACCESS);
  assign bus.PENABLE = (state == ACCESS);
  assign bus.PWRITE  = req_q.wr;
  assign bus.PADDR   = req_q.addr;
  assign bus.PWDATA  = req_q.data;
  assign bus.PSTRB   = req_q.strb;

  assign bus.wr_rsp_valid = (state == WRSP);
  assign bus.wr_rsp_err   = rsp_err;
  assign bus.rd_rsp_valid = (state == RRSP);
  assign bus.rd_rsp_err   = rsp_err;
  assign bus.rd_rsp_data  = rsp_data;
endmodule

// File: tb/tb_apb_rw_scheduler.sv
// Randomized bench for apb_rw_scheduler: transaction model of the two requesters,
// round-robin grant prediction and an APB completer with random wait states.
module tb_apb_rw_scheduler;
  localparam int AW = 32, DW = 32, SW = 4, TMO = 16;

  logic ACLK = 1'b0, ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  apb_rw_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  apb_rw_scheduler #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus)
  );

  int n_chk = 0, n_err = 0;

  // model: pending request per requester and the last granted type
  bit            pw, pr, last_wr, g_wr;
  logic [AW-1:0] pw_addr, pr_addr;
  logic [DW-1:0] pw_data;
  logic [SW-1:0] pw_strb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_req();
    bus.wr_req_valid = pw; bus.wr_addr = pw_addr; bus.wr_data = pw_data; bus.wr_strb = pw_strb;
    bus.rd_req_valid = pr; bus.rd_addr = pr_addr;
  endtask

  task automatic new_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    pw = 1'b1; pw_addr = a; pw_data = d; pw_strb = s;
  endtask

  task automatic new_rd(input logic [AW-1:0] a);
    pr = 1'b1; pr_addr = a;
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge, idle again.
  task automatic xfer(input int waits, input bit slverr, input logic [DW-1:0] prdata, input int rsp_dly);
    bit exp_wr, tmo;
    int n_acc;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    drive_req();
    #1;
    exp_wr = pw && (!pr || !last_wr);
    check("wr_req_ready", bus.wr_req_ready, exp_wr);
    check("rd_req_ready", bus.rd_req_ready, !exp_wr);
    g_wr    = bus.wr_req_ready;
    last_wr = exp_wr;
    if (exp_wr) begin ea = pw_addr; ed = pw_data; es = pw_strb; pw = 1'b0; end
    else        begin ea = pr_addr; ed = '0;      es = '0;      pr = 1'b0; end

    @(negedge ACLK);
    drive_req();
    #1;
    check("stall_ready", {bus.wr_req_ready, bus.rd_req_ready}, 2'b00);
    check("setup_ctl",   {bus.PSEL, bus.PENABLE, bus.PWRITE}, {2'b10, exp_wr});
    check("setup_paddr", bus.PADDR, ea);
    check("setup_pwdata", bus.PWDATA, ed);
    check("setup_pstrb", bus.PSTRB, es);

    tmo = 1'b0; n_acc = waits + 1;
`ifdef APB_TIMEOUT_EN
    if (waits >= TMO) begin tmo = 1'b1; n_acc = TMO; end
`endif
    for (int i = 0; i < n_acc; i++) begin
      @(negedge ACLK);
      if (!tmo && i == waits) begin
        bus.PREADY = 1'b1; bus.PRDATA = prdata; bus.PSLVERR = slverr;
      end else begin
        bus.PREADY = 1'b0; bus.PRDATA = $urandom; bus.PSLVERR = 1'($urandom_range(0, 1));
      end
      #1;
      check("access_ctl",   {bus.PSEL, bus.PENABLE, bus.PWRITE}, {2'b11, exp_wr});
      check("access_paddr", bus.PADDR, ea);
      check("access_pwdata", bus.PWDATA, ed);
      check("access_pstrb", bus.PSTRB, es);
      check("access_norsp", {bus.wr_rsp_valid, bus.rd_rsp_valid}, 2'b00);
    end

    @(negedge ACLK);
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    for (int i = 0; i <= rsp_dly; i++) begin
      if (i == rsp_dly) begin
        bus.wr_rsp_ready = exp_wr; bus.rd_rsp_ready = !exp_wr;
      end
      #1;
      check("rsp_ctl",   {bus.PSEL, bus.PENABLE}, 2'b00);
      check("rsp_paddr", bus.PADDR, ea);
      check("rsp_pstrb", bus.PSTRB, es);
      check("rsp_valid", {bus.wr_rsp_valid, bus.rd_rsp_valid}, exp_wr ? 2'b10 : 2'b01);
      check("rsp_err",   exp_wr ? bus.wr_rsp_err : bus.rd_rsp_err, tmo || slverr);
      if (!exp_wr) check("rsp_data", bus.rd_rsp_data, tmo ? '0 : prdata);
      @(negedge ACLK);
    end
    bus.wr_rsp_ready = 1'b0; bus.rd_rsp_ready = 1'b0;
    #1;
    check("rsp_done", {bus.wr_rsp_valid, bus.rd_rsp_valid}, 2'b00);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && (pw || pr); i++) xfer(0, 1'b0, $urandom, 0);
  endtask

  initial begin
    pw = 1'b0; pr = 1'b0; last_wr = 1'b0; g_wr = 1'b0;
    pw_addr = '0; pw_data = '0; pw_strb = '0; pr_addr = '0;
    bus.wr_rsp_ready = 1'b0; bus.rd_rsp_ready = 1'b0;
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
    new_wr(32'h100, 32'h1111_2222, 4'hF);
    new_rd(32'h104);
    drive_req();

    // reset state, with both requesters already valid
    repeat (2) @(negedge ACLK);
    #1;
    check("rst_ctl",   {bus.PSEL, bus.PENABLE, bus.PWRITE}, 3'b000);
    check("rst_paddr", bus.PADDR, '0);
    check("rst_ready", {bus.wr_req_ready, bus.rd_req_ready}, 2'b00);
    check("rst_rsp",   {bus.wr_rsp_valid, bus.rd_rsp_valid}, 2'b00);
    @(negedge ACLK);
    ARESETn = 1'b1;

    // both valids held across four transfers: W,R,W,R
    for (int k = 0; k < 4; k++) begin
      if (!pw) new_wr($urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom));
      if (!pr) new_rd($urandom & 32'hFFFF_FFFC);
      xfer($urandom_range(0, 2), 1'b0, $urandom, 0);
      check("tie_grant", g_wr, (k % 2) == 0);
    end
    drain();

    // minimum-latency write
    new_wr(32'h10, 32'hDEAD_BEEF, 4'hF);
    xfer(0, 1'b0, '0, 0);
    // read with three wait states
    new_rd(32'h20);
    xfer(3, 1'b0, 32'h1234_5678, 0);
    // slave error, response held five cycles
    new_wr(32'h24, 32'hCAFE_F00D, 4'h3);
    xfer(0, 1'b1, '0, 5);
    // long stall: watchdog aborts after TMO cycles if enabled, else waits it out
    new_rd(32'h30);
    xfer(TMO + 4, 1'b0, 32'h5A5A_A5A5, 1);

    // reset in ACCESS abandons a write that was granted last
    new_wr(32'h40, 32'h0BAD_F00D, 4'hC);
    drive_req();
    last_wr = 1'b1;
    @(negedge ACLK);
    pw = 1'b0; drive_req();
    @(negedge ACLK);
    bus.PREADY = 1'b0;
    #2 ARESETn = 1'b0;
    #1;
    check("arst_ctl",   {bus.PSEL, bus.PENABLE}, 2'b00);
    check("arst_paddr", bus.PADDR, '0);
    check("arst_rsp",   {bus.wr_rsp_valid, bus.rd_rsp_valid}, 2'b00);
    last_wr = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("arst_norsp", {bus.wr_rsp_valid, bus.rd_rsp_valid, bus.PSEL}, 3'b000);
      @(negedge ACLK);
    end
    new_wr(32'h44, 32'h7777_8888, 4'h1);
    new_rd(32'h48);
    xfer(0, 1'b0, '0, 0);
    check("arst_tie_wr", g_wr, 1'b1);
    drain();

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if (!pw && $urandom_range(0, 1) == 1) new_wr($urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom));
      if (!pr && $urandom_range(0, 1) == 1) new_rd($urandom & 32'hFFFF_FFFC);
      if (!pw && !pr) new_rd($urandom & 32'hFFFF_FFFC);
      xfer($urandom_range(0, 4), $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
